regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb.sv | 147 ++++++++++++++
 tb/tb_regfile_wb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Register bank with a small write-back queue in front of it. Writes are
// accepted into a FIFO and committed one per cycle to the bank, so a stall
// (hold) or a discard (flush) can act on not-yet-committed writes.
module regfile_wb #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREG  = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [3:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             hold,
   input  logic             flush,
   output logic [WIDTH-1:0] R0,
   output logic [WIDTH-1:0] R1,
   output logic [WIDTH-1:0] R2,
   output logic [WIDTH-1:0] R3,
   output logic [WIDTH-1:0] R4,
   output logic [WIDTH-1:0] R5,
   output logic [WIDTH-1:0] R6,
   output logic [WIDTH-1:0] R7,
   output logic [WIDTH-1:0] R8,
   output logic [WIDTH-1:0] R9,
   output logic [WIDTH-1:0] R10,
   output logic [WIDTH-1:0] R11,
   output logic [WIDTH-1:0] R12,
   output logic [WIDTH-1:0] R13,
   output logic [WIDTH-1:0] R14,
   output logic [WIDTH-1:0] R15,
   output logic [NREG-1:0]  pending,
   output logic             empty
);

   localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned    CntW    = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [3:0]       q_addr_q [DEPTH];
   logic [WIDTH-1:0] q_data_q [DEPTH];
   // Per-slot valid bits mirror count; they make the pending decode direct.
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   logic full;
   logic accept;
   logic commit;

   function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   assign full     = (count_q == FullCnt);
   assign empty    = (count_q == '0);
   // Ready depends only on stored state and flush/rst, never on a same-cycle commit.
   assign wr_ready = !full && !flush && !rst;
   assign accept   = wr_valid && wr_ready;
   assign commit   = (count_q != '0) && !hold && !flush && !rst;

   // Next-state: flush wins over commit/accept; otherwise pop head and push tail.
   always_comb begin
      regs_d   = regs_q;
      vld_d    = vld_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         vld_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (commit) begin
            regs_d[q_addr_q[rd_ptr_q]] = q_data_q[rd_ptr_q];
            vld_d[rd_ptr_q]            = 1'b0;
            rd_ptr_d                   = inc_ptr(rd_ptr_q);
         end
         if (accept) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = inc_ptr(wr_ptr_q);
         end
         unique case ({accept, commit})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state and register bank, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         regs_q   <= regs_d;
         vld_q    <= vld_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue payload storage; only written at the accepting edge, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         q_addr_q[wr_ptr_q] <= wr_addr;
         q_data_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pending: OR of one-hot decodes of every valid queued address.
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) pending[q_addr_q[i]] = 1'b1;
      end
   end

   assign R0  = regs_q[0];
   assign R1  = regs_q[1];
   assign R2  = regs_q[2];
   assign R3  = regs_q[3];
   assign R4  = regs_q[4];
   assign R5  = regs_q[5];
   assign R6  = regs_q[6];
   assign R7  = regs_q[7];
   assign R8  = regs_q[8];
   assign R9  = regs_q[9];
   assign R10 = regs_q[10];
   assign R11 = regs_q[11];
   assign R12 = regs_q[12];
   assign R13 = regs_q[13];
   assign R14 = regs_q[14];
   assign R15 = regs_q[15];

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vector table, hand sequences and random
// stimulus, all compared against a queue-based reference model.
module tb_regfile_wb;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, wr_valid, wr_ready, hold, flush, empty;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [15:0] pending;
   logic [31:0] r [16];

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mreg [16];
   logic        m_rdy;
   logic        rdy_seen;

   typedef struct {
      logic        r, v;
      logic [3:0]  a;
      logic [31:0] d;
      logic        h, f;
      logic        rdy;   // expected wr_ready before the edge
      logic [3:0]  ra;    // register checked after the edge
      logic [31:0] rv;
      logic [15:0] pend;
      logic        emp;
   } vec_t;

   vec_t tbl [17];

   always #5 clk = ~clk;

   regfile_wb #(.WIDTH(32), .NREG(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .flush(flush),
      .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]), .R4(r[4]), .R5(r[5]),
      .R6(r[6]), .R7(r[7]), .R8(r[8]), .R9(r[9]), .R10(r[10]), .R11(r[11]),
      .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
      .pending(pending), .empty(empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, check ready, advance model and DUT, compare all.
   task automatic step(input logic r_, input logic v_, input logic [3:0] a_,
                       input logic [31:0] d_, input logic h_, input logic f_);
      logic [15:0] mp;
      ent_t        e;
      rst = r_; wr_valid = v_; wr_addr = a_; wr_data = d_; hold = h_; flush = f_;
      #1;
      rdy_seen = wr_ready;
      m_rdy    = (mq.size() < DEPTH) && !f_ && !r_;
      chk("wr_ready", 32'(wr_ready), 32'(m_rdy));
      @(posedge clk);
      if (r_) begin
         for (int i = 0; i < 16; i++) mreg[i] = '0;
         mq.delete();
      end else if (f_) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && !h_) begin
            e = mq.pop_front();
            mreg[e.a] = e.d;
         end
         if (v_ && m_rdy) mq.push_back('{a: a_, d: d_});
      end
      #1;
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), r[i], mreg[i]);
      mp = '0;
      foreach (mq[i]) mp = mp | (16'(1) << mq[i].a);
      chk("pending", 32'(pending), 32'(mp));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0; flush = 1'b0;
      for (int i = 0; i < 16; i++) mreg[i] = '0;

      //          r  v  a   d             h  f  rdy ra  rv            pend      emp
      tbl[0]  = '{1, 1, 5, 32'h1,        0, 0, 0,  5, 32'h0,        16'h0000, 1};
      tbl[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 1,  5, 32'h0,        16'h0020, 0};
      tbl[2]  = '{0, 0, 0, 32'h0,        0, 0, 1,  5, 32'hDEADBEEF, 16'h0000, 1};
      tbl[3]  = '{0, 1, 3, 32'h11,       1, 0, 1,  3, 32'h0,        16'h0008, 0};
      tbl[4]  = '{0, 1, 3, 32'h22,       1, 0, 1,  3, 32'h0,        16'h0008, 0};
      tbl[5]  = '{0, 1, 3, 32'h33,       1, 0, 0,  3, 32'h0,        16'h0008, 0};
      tbl[6]  = '{0, 0, 0, 32'h0,        0, 0, 0,  3, 32'h11,       16'h0008, 0};
      tbl[7]  = '{0, 0, 0, 32'h0,        0, 0, 1,  3, 32'h22,       16'h0000, 1};
      tbl[8]  = '{0, 1, 7, 32'hAA,       1, 0, 1,  7, 32'h0,        16'h0080, 0};
      tbl[9]  = '{0, 1, 7, 32'hAA,       1, 0, 1,  7, 32'h0,        16'h0080, 0};
      tbl[10] = '{0, 1, 7, 32'hBB,       0, 1, 0,  7, 32'h0,        16'h0000, 1};
      tbl[11] = '{0, 0, 0, 32'h0,        0, 0, 1,  7, 32'h0,        16'h0000, 1};
      tbl[12] = '{0, 1, 9, 32'h55,       1, 0, 1,  9, 32'h0,        16'h0200, 0};
      tbl[13] = '{0, 1, 9, 32'h66,       1, 0, 1,  9, 32'h0,        16'h0200, 0};
      tbl[14] = '{1, 0, 0, 32'h0,        0, 0, 0,  3, 32'h0,        16'h0000, 1};
      tbl[15] = '{0, 0, 0, 32'h0,        0, 0, 1,  9, 32'h0,        16'h0000, 1};
      tbl[16] = '{0, 0, 0, 32'h0,        0, 0, 1,  5, 32'h0,        16'h0000, 1};

      for (int k = 0; k < 17; k++) begin
         step(tbl[k].r, tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].h, tbl[k].f);
         chk($sformatf("vec%0d_ready", k), 32'(rdy_seen), 32'(tbl[k].rdy));
         chk($sformatf("vec%0d_R%0d", k, tbl[k].ra), r[tbl[k].ra], tbl[k].rv);
         chk($sformatf("vec%0d_pending", k), 32'(pending), 32'(tbl[k].pend));
         chk($sformatf("vec%0d_empty", k), 32'(empty), 32'(tbl[k].emp));
      end

      // Back-to-back writes: accept and commit share every edge, occupancy stays 1.
      for (int n = 0; n < 16; n++) begin
         step(1'b0, 1'b1, 4'(n), 32'(n) * 32'h101, 1'b0, 1'b0);
         chk("stream_ready", 32'(rdy_seen), 32'd1);
         chk("stream_nonempty", 32'(empty), 32'd0);
      end
      step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      for (int n = 0; n < 16; n++) chk($sformatf("stream_R%0d", n), r[n], 32'(n) * 32'h101);

      // Alternating hold with continuous writes exercises pointer wrap.
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, k[0], 1'b0);
      end

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 11) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
